u41_cfg_shifter: RTL

- Downstream consumer of the 4-input permutation normaliser.
- Accepts one {norm[15:0], perm[7:0]} result per valid/ready transfer and validates that perm is a true permutation.
- Serialises each valid result onto the configuration scan chain of a universal-gate cell, then pulses a latch strobe.
- Has one skid/holding entry, so the normaliser can hand over the next result while the current one is still shifting.

---
 rtl/u41_cfg_shifter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/u41_cfg_shifter.sv
// u41_cfg_shifter
//
// Takes normalised gate configurations {norm, perm} from the 4-input
// permutation normaliser and streams each one, MSB first, into the
// configuration scan chain of a universal-gate cell. A latch strobe follows
// the last bit. One holding entry lets the upstream stage hand over the
// next result while the current frame is still shifting.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   in_valid    norm/perm presented
//   in_ready    block can accept this cycle (registered, = !holding full)
//   in_norm     normalised truth table, bit 15 = row 0
//   in_perm     {p3,p2,p1,p0}, two bits each; must be a permutation of 0..3
//   scan_data   serial frame bit, MSB first
//   scan_en     high while scan_data carries a frame bit
//   scan_tick   one-cycle pulse on the last cycle of each bit
//   scan_latch  one-cycle pulse after the last bit of a frame
//   busy        frame shifting, latch pending, or holding entry full
//   err         one-cycle pulse when an accepted perm is not a permutation
//
// Parameters
//   DIV    clk cycles per scan bit, 1..255
//   NBITS  frame length, 16 norm bits + 8 perm bits; keep at 24
module u41_cfg_shifter #(
  parameter int DIV   = 1,
  parameter int NBITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_norm,
  input  logic [7:0]  in_perm,
  output logic        scan_data,
  output logic        scan_en,
  output logic        scan_tick,
  output logic        scan_latch,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(NBITS - 1);

  // A perm is usable only if the four slot selectors are pairwise distinct.
  function automatic logic perm_ok(input logic [7:0] p);
    logic [1:0] w_p0, w_p1, w_p2, w_p3;
    {w_p3, w_p2, w_p1, w_p0} = p;
    return (w_p0 != w_p1) && (w_p0 != w_p2) && (w_p0 != w_p3) &&
           (w_p1 != w_p2) && (w_p1 != w_p3) && (w_p2 != w_p3);
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NBITS-1:0]   r_shreg;
  logic [7:0]         r_div_cnt;
  logic [4:0]         r_bit_cnt;
  logic               r_hold_full;
  logic [15:0]        r_hold_norm;
  logic [7:0]         r_hold_perm;
  logic               r_err;

  logic               w_xfer;
  logic               w_tick;
  logic               w_in_ok;
  logic               w_hold_ok;
  logic               w_load;
  logic               w_load_hold;
  logic               w_hold_set;
  logic               w_hold_clr;
  logic               w_err_nxt;

  assign w_xfer    = in_valid && !r_hold_full;
  assign w_tick    = (r_state == ST_SHIFT) && (r_div_cnt == DIV_LAST);
  assign w_in_ok   = perm_ok(in_perm);
  assign w_hold_ok = perm_ok(r_hold_perm);

  // Next-state and datapath control. The holding entry drains in LATCH,
  // or in IDLE when it was filled during the LATCH cycle itself. Outside
  // IDLE every transfer lands in the holding entry; its perm is only
  // judged when it drains.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_hold = 1'b0;
    w_hold_set  = 1'b0;
    w_hold_clr  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_hold_clr = 1'b1;
          if (w_hold_ok) begin
            w_load      = 1'b1;
            w_load_hold = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (w_xfer) begin
          if (w_in_ok) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        w_hold_set = w_xfer;
        if (w_tick && (r_bit_cnt == BIT_LAST)) begin
          w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        w_state_nxt = ST_IDLE;
        w_hold_set  = w_xfer;
        if (r_hold_full) begin
          w_hold_clr = 1'b1;
          if (w_hold_ok) begin
            w_load      = 1'b1;
            w_load_hold = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control state: FSM, holding flag, counters, error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hold_full <= 1'b0;
      r_err       <= 1'b0;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_hold_set) begin
        r_hold_full <= 1'b1;
      end else if (w_hold_clr) begin
        r_hold_full <= 1'b0;
      end
      if (w_load) begin
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
      end else if (w_tick) begin
        r_div_cnt <= '0;
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end else if (r_state == ST_SHIFT) begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end
    end
  end

  // Frame data: shift register and holding payload carry no reset; they
  // are only observed while the control state says they are meaningful.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_shreg <= w_load_hold ? {r_hold_norm, r_hold_perm} : {in_norm, in_perm};
    end else if (w_tick) begin
      r_shreg <= {r_shreg[NBITS-2:0], 1'b0};
    end
    if (w_hold_set) begin
      r_hold_norm <= in_norm;
      r_hold_perm <= in_perm;
    end
  end

  assign in_ready   = !r_hold_full;
  assign scan_en    = (r_state == ST_SHIFT);
  assign scan_data  = scan_en && r_shreg[NBITS-1];
  assign scan_tick  = w_tick;
  assign scan_latch = (r_state == ST_LATCH);
  assign busy       = (r_state != ST_IDLE) || r_hold_full;
  assign err        = r_err;

endmodule
